// File: rtl/data_mem_resp.sv
// Word-organised data-memory responder with registered read data and error pulse.
// A zero-fill scrub runs after every reset; accesses are only served once it completes.
module data_mem_resp #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_read_en_i,
    input  logic            mem_write_en_i,
    input  logic [XLEN-1:0] mem_write_data_i,
    output logic [XLEN-1:0] mem_read_data_o,
    output logic            mem_err_o,
    output logic            mem_busy_o
);

    localparam int unsigned     AW   = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * 4);
    localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   scrub_idx_q, scrub_idx_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic [XLEN-1:0] off;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            aligned;
    logic            legal;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    always_comb begin
        off      = mem_addr_i - BASE_ADDR;
        idx      = off[AW+1:2];
        in_range = (off < SPAN);
        aligned  = (mem_addr_i[1:0] == 2'b00);
        legal    = in_range && aligned;

        state_d     = state_q;
        scrub_idx_d = scrub_idx_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_wdata   = mem_write_data_i;

        case (state_q)
            ST_SCRUB: begin
                // The scrub owns the write port; core requests are silently dropped.
                mem_we      = 1'b1;
                mem_waddr   = scrub_idx_q;
                mem_wdata   = '0;
                scrub_idx_d = scrub_idx_q + 1'b1;
                if (scrub_idx_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (mem_read_en_i || mem_write_en_i) begin
                    if (!legal) begin
                        err_d = 1'b1;
                        if (mem_read_en_i) begin
                            rdata_d = '0;
                        end
                    end else begin
                        mem_we = mem_write_en_i;
                        // Collision: the write lands and the read returns the new word.
                        if (mem_read_en_i && mem_write_en_i) begin
                            rdata_d = mem_write_data_i;
                            err_d   = 1'b1;
                        end else if (mem_read_en_i) begin
                            rdata_d = mem_q[idx];
                        end
                    end
                end
            end
            default: begin
                state_d = ST_SCRUB;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= ST_SCRUB;
            scrub_idx_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            scrub_idx_q <= scrub_idx_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Array contents are left alone while reset is held.
    always_ff @(posedge clk_i) begin
        if (resetn_i && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign mem_read_data_o = rdata_q;
    assign mem_err_o       = err_q;
    assign mem_busy_o      = (state_q == ST_SCRUB);

endmodule
